xbar_periph_port: RTL

//  Per-peripheral crossbar port, directly downstream of xbar_priority_selector. Takes the one-hot

---
 rtl/xbar_pkg.sv | 43 ++++
 rtl/xbar_periph_port_if.sv | 50 +++++
 rtl/xbar_timeout_cnt.sv | 38 +++
 rtl/xbar_periph_port.sv | 88 ++++++++
 4 files changed

// File: rtl/xbar_pkg.sv
// Shared types and helpers for the per-peripheral crossbar port.
// Request/response structs are sized from the package widths.
package xbar_pkg;

  localparam int NUM_MASTERS = 3;
  localparam int XBAR_WAW    = 30;
  localparam int XBAR_DW     = 32;
  localparam int XBAR_BEW    = XBAR_DW / 8;

  typedef enum logic [1:0] {
    IDX_IMEM = 2'd0,
    IDX_DMEM = 2'd1,
    IDX_DBG  = 2'd2
  } master_idx_e;

  typedef struct packed {
    logic [XBAR_WAW-1:0] addr;
    logic                we;
    logic [XBAR_BEW-1:0] be;
    logic [XBAR_DW-1:0]  wdata;
  } xbar_req_t;

  typedef struct packed {
    logic [XBAR_DW-1:0] rdata;
    logic               err;
  } xbar_rsp_t;

  // The selection is one-hot, so the highest set bit is the only set bit.
  function automatic master_idx_e sel_to_idx(input logic [NUM_MASTERS-1:0] sel);
    master_idx_e idx;
    idx = IDX_IMEM;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (sel[i]) idx = master_idx_e'(2'(i));
    end
    return idx;
  endfunction

  // A disabled watchdog still keeps a one-bit counter so port widths stay legal.
  function automatic int cnt_width(input int timeout_cycles);
    return (timeout_cycles > 0) ? $clog2(timeout_cycles + 1) : 1;
  endfunction

endpackage

// File: rtl/xbar_periph_port_if.sv
// Master-side and peripheral-side signals of one crossbar port.
// Handshake: an access is presented while its sel_i bit is high and completes in the
// cycle xfer_done_o is high (m_gnt_o); the response follows as a one-cycle m_rvalid_o pulse.
interface xbar_periph_port_if
  import xbar_pkg::*;
#(
  parameter int WAW            = XBAR_WAW,
  parameter int DW             = XBAR_DW,
  parameter int TIMEOUT_CYCLES = 16
) ();

  localparam int BEW = DW / 8;
  localparam int CW  = cnt_width(TIMEOUT_CYCLES);

  logic [NUM_MASTERS-1:0]          sel_i;
  logic [NUM_MASTERS-1:0][WAW-1:0] m_addr_i;
  logic [NUM_MASTERS-1:0]          m_we_i;
  logic [NUM_MASTERS-1:0][BEW-1:0] m_be_i;
  logic [NUM_MASTERS-1:0][DW-1:0]  m_wdata_i;
  logic [NUM_MASTERS-1:0]          m_gnt_o;
  logic [NUM_MASTERS-1:0]          m_rvalid_o;
  logic [DW-1:0]                   m_rdata_o;
  logic                            m_err_o;

  logic                            p_sel_o;
  logic [WAW-1:0]                  p_addr_o;
  logic                            p_we_o;
  logic [BEW-1:0]                  p_be_o;
  logic [DW-1:0]                   p_wdata_o;
  logic                            p_abort_o;
  logic [DW-1:0]                   p_rdata_i;
  logic                            p_ready_i;
  logic                            xfer_done_o;
  logic [CW-1:0]                   dbg_cnt_o;

  modport slave (
    input  sel_i, m_addr_i, m_we_i, m_be_i, m_wdata_i, p_rdata_i, p_ready_i,
    output m_gnt_o, m_rvalid_o, m_rdata_o, m_err_o,
    output p_sel_o, p_addr_o, p_we_o, p_be_o, p_wdata_o, p_abort_o,
    output xfer_done_o, dbg_cnt_o
  );

  modport master (
    output sel_i, m_addr_i, m_we_i, m_be_i, m_wdata_i, p_rdata_i, p_ready_i,
    input  m_gnt_o, m_rvalid_o, m_rdata_o, m_err_o,
    input  p_sel_o, p_addr_o, p_we_o, p_be_o, p_wdata_o, p_abort_o,
    input  xfer_done_o, dbg_cnt_o
  );

endinterface

// File: rtl/xbar_timeout_cnt.sv
// Bus-timeout watchdog: counts stalled cycles of the current access and flags the
// TIMEOUT_CYCLES-th stalled cycle. TIMEOUT_CYCLES = 0 disables it.
module xbar_timeout_cnt
  import xbar_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CW             = cnt_width(TIMEOUT_CYCLES)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          i_active,
  input  logic          i_ready,
  output logic          o_timeout,
  output logic [CW-1:0] o_cnt
);

  localparam bit            ENABLED = (TIMEOUT_CYCLES > 0);
  localparam logic [CW-1:0] LAST    = ENABLED ? CW'(TIMEOUT_CYCLES - 1) : '0;

  logic [CW-1:0] r_cnt;
  logic          w_stall;

  assign w_stall   = i_active & ~i_ready;
  assign o_timeout = ENABLED & w_stall & (r_cnt == LAST);
  assign o_cnt     = r_cnt;

  // Any completion (ready or forced) or an idle bus restarts the count.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt <= '0;
    end else if (!ENABLED || !w_stall || o_timeout) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/xbar_periph_port.sv
// Per-peripheral crossbar port: muxes the selected master onto the peripheral bus,
// routes grant back, registers the response and enforces a stall watchdog.
module xbar_periph_port
  import xbar_pkg::*;
#(
  parameter int WORD_ADDR_WIDTH = XBAR_WAW,
  parameter int DATA_WIDTH      = XBAR_DW,
  parameter int TIMEOUT_CYCLES  = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  xbar_periph_port_if.slave bus
);

  xbar_req_t [NUM_MASTERS-1:0] w_req;
  xbar_req_t                   w_sel_req;
  master_idx_e                 w_idx;
  logic                        w_active;
  logic                        w_timeout;
  logic                        w_done;

  logic [NUM_MASTERS-1:0]      r_rvalid;
  xbar_rsp_t                   r_rsp;

  // Reset also forces the combinational request path to zero.
  assign w_active = rst_ni & (|bus.sel_i);

  always_comb begin
    w_req = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      w_req[i].addr  = bus.m_addr_i[i][WORD_ADDR_WIDTH-1:0];
      w_req[i].we    = bus.m_we_i[i];
      w_req[i].be    = bus.m_be_i[i][DATA_WIDTH/8-1:0];
      w_req[i].wdata = bus.m_wdata_i[i][DATA_WIDTH-1:0];
    end
  end

  assign w_idx     = sel_to_idx(bus.sel_i);
  assign w_sel_req = w_active ? w_req[w_idx] : '0;

  xbar_timeout_cnt #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout_cnt (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .i_active  (w_active),
    .i_ready   (bus.p_ready_i),
    .o_timeout (w_timeout),
    .o_cnt     (bus.dbg_cnt_o)
  );

  // p_ready_i has priority: the watchdog only fires while ready is low.
  assign w_done = w_active & (bus.p_ready_i | w_timeout);

  assign bus.p_sel_o     = w_active;
  assign bus.p_addr_o    = w_sel_req.addr;
  assign bus.p_we_o      = w_sel_req.we;
  assign bus.p_be_o      = w_sel_req.be;
  assign bus.p_wdata_o   = w_sel_req.wdata;
  assign bus.p_abort_o   = w_timeout;
  assign bus.xfer_done_o = w_done;
  assign bus.m_gnt_o     = bus.sel_i & {NUM_MASTERS{w_done}};

  // Writes and aborted accesses return zero data; rdata/err hold between responses.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rvalid <= '0;
      r_rsp    <= '0;
    end else if (w_done) begin
      r_rvalid    <= bus.sel_i;
      r_rsp.err   <= w_timeout;
      r_rsp.rdata <= (w_timeout | w_sel_req.we) ? '0 : bus.p_rdata_i;
    end else begin
      r_rvalid <= '0;
    end
  end

  assign bus.m_rvalid_o = r_rvalid;
  assign bus.m_rdata_o  = r_rsp.rdata;
  assign bus.m_err_o    = r_rsp.err;

  a_sel_onehot : assert property (@(posedge clk_i) disable iff (!rst_ni)
    $onehot0(bus.sel_i));

  a_sel_stable : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (w_active && !w_done) |=> (bus.sel_i == $past(bus.sel_i)));

endmodule
